// File: rtl/slc3_mem_responder_pkg.sv
// Shared types and constants for the SLC-3 memory responder and its bench.
package slc3_mem_pkg;
  localparam int WORD_W         = 16;
  localparam int DEF_MEM_DEPTH  = 1024;
  localparam int DEF_INIT_WORDS = 256;

  typedef enum logic [1:0] {
    MEM_INIT,
    MEM_DRAIN,
    MEM_READY
  } mem_state_t;
endpackage

// File: rtl/slc3_mem_responder_if.sv
// Core-side MAR/MDR bus: active-low OE/WE strobes, word address, data both ways, ready flag.
interface slc3_mem_if;
  import slc3_mem_pkg::*;
  logic [WORD_W-1:0] ADDR;
  logic              OE;
  logic              WE;
  logic [WORD_W-1:0] Data_to_SRAM;
  logic [WORD_W-1:0] Data_from_SRAM;
  logic              mem_ready;

  modport master (
    output ADDR, OE, WE, Data_to_SRAM,
    input  Data_from_SRAM, mem_ready
  );

  modport slave (
    input  ADDR, OE, WE, Data_to_SRAM,
    output Data_from_SRAM, mem_ready
  );
endinterface

// File: rtl/slc3_mem_responder_bram.sv
// Single-port synchronous word RAM, write-first, no reset so it maps onto block RAM.
// One-cycle read latency; the port is always enabled, callers decide when dout matters.
module slc3_bram_sp
  import slc3_mem_pkg::*;
#(
  parameter int DEPTH = DEF_MEM_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] dout
);
  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
      dout      <= din;
    end else begin
      dout      <= mem[addr];
    end
  end
endmodule

// File: rtl/slc3_mem_responder.sv
// Memory responder: copies the ROM image into RAM after reset, then serves core OE/WE accesses.
// Read data appears one cycle after the access is sampled; no backpressure, mem_ready gates the core.
module slc3_mem_responder
  import slc3_mem_pkg::*;
#(
  parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
  parameter int INIT_WORDS = DEF_INIT_WORDS
) (
  input  logic              Clk,
  input  logic              Reset_n,
  slc3_mem_if.slave         bus,
  output logic [WORD_W-1:0] rom_addr,
  input  logic [WORD_W-1:0] rom_data
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [WORD_W-1:0] LAST_ADDR = (INIT_WORDS == 0) ? '0 : WORD_W'(INIT_WORDS - 1);

  mem_state_t        state, state_nxt;
  logic [AW-1:0]     copy_cnt, ram_addr, idx;
  logic              ram_we, acc, rd_pend;
  logic [WORD_W-1:0] ram_din, ram_dout, held;
  logic              unused_addr_hi;

  // Upper address bits alias onto the RAM, by design.
  assign idx            = bus.ADDR[AW-1:0];
  assign unused_addr_hi = ^bus.ADDR[WORD_W-1:AW];

  always_comb begin
    state_nxt = state;
    ram_we    = 1'b0;
    ram_addr  = idx;
    ram_din   = bus.Data_to_SRAM;
    acc       = 1'b0;
    unique case (state)
      MEM_INIT: begin
        // ROM data lags its address by one cycle, so nothing to write on the first fetch.
        ram_addr = copy_cnt;
        ram_din  = rom_data;
        ram_we   = (INIT_WORDS != 0) && (rom_addr != '0);
        if (INIT_WORDS == 0)
          state_nxt = MEM_READY;
        else if (rom_addr == LAST_ADDR)
          state_nxt = MEM_DRAIN;
      end
      MEM_DRAIN: begin
        ram_addr  = copy_cnt;
        ram_din   = rom_data;
        ram_we    = 1'b1;
        state_nxt = MEM_READY;
      end
      MEM_READY: begin
        ram_we = ~bus.WE;
        acc    = ~bus.WE | ~bus.OE;
      end
      default: state_nxt = MEM_INIT;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= MEM_INIT;
      rom_addr <= '0;
      copy_cnt <= '0;
      rd_pend  <= 1'b0;
      held     <= '0;
    end else begin
      state <= state_nxt;
      if (state == MEM_INIT && state_nxt == MEM_INIT)
        rom_addr <= rom_addr + WORD_W'(1);
      if (ram_we && state != MEM_READY)
        copy_cnt <= copy_cnt + AW'(1);
      rd_pend <= acc;
      held    <= bus.Data_from_SRAM;
    end
  end

  slc3_bram_sp #(.DEPTH(MEM_DEPTH), .AW(AW)) u_ram (
    .clk  (Clk),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (ram_din),
    .dout (ram_dout)
  );

  // The RAM output is only meaningful right after an access; otherwise replay the last value.
  assign bus.Data_from_SRAM = rd_pend ? ram_dout : held;
  assign bus.mem_ready      = (state == MEM_READY);
endmodule
